gb_window_bridge: RTL and testbench
===================================

# gb_window_bridge

Single-clock address-window stage that sits directly upstream of `bus_glue`. It decodes a ghostbus host transaction against a power-of-two window. On a hit it trims the address to the window's low bits and drives a registered sub-bus (`parent_*` side of `bus_glue`). It returns the sub-bus read data to the host with a fixed, parameterised latency, and returns zero on misses.

## Interface

Parameters:
- `AW`, 24: host and sub-bus address width.
- `DW`, 32: data width.
- `SUB_AW`, 8: window size is 2^SUB_AW words. Range 1..AW-1.
- `BASE`, 24'h000100: window base address. Must be aligned to 2^SUB_AW. An unaligned `BASE` is an elaboration error.
- `RD_LAT`, 1: sub-bus read latency in cycles, counted from `sub_addr` being presented to `sub_rdata` being valid. Range 1..8.

Ports:
- `gb_clk` in 1: the only clock.
- `gb_rst_n` in 1: reset, asynchronous, active-low.
- `gb_addr` in AW: host address.
- `gb_wdata` in DW: host write data.
- `gb_wstb` in 1: host write strobe. A cycle with this low is a read.
- `gb_rdata` out DW: host read data (registered).
- `sub_addr` out AW: trimmed sub-bus address (registered).
- `sub_wdata` out DW: sub-bus write data (registered).
- `sub_wstb` out 1: sub-bus write strobe (registered).
- `sub_rdata` in DW: sub-bus read data.
- `wr_count` out 16: saturating count of accepted window writes.

## Operation

- **Hit decode:** `hit = (gb_addr[AW-1:SUB_AW] == BASE[AW-1:SUB_AW])`. This is combinational and internal only.
- **Request stage (one register):**
  - On a hit, `sub_addr <= {zeros, gb_addr[SUB_AW-1:0]}` and `sub_wdata <= gb_wdata`.
  - On a miss, `sub_addr` and `sub_wdata` hold their previous values, so the sub-bus stays quiet on misses.
  - `sub_wstb <= gb_wstb & hit` every cycle. It is never asserted on a miss.
- **Read issue:** `rd_issue = hit & ~gb_wstb`.
  - `rd_issue` enters a shift register of length 1+RD_LAT.
  - A write cycle or a miss shifts in 0.
- **Read return:** when the tap aligned with `sub_rdata` validity is 1, `gb_rdata <= sub_rdata`. Otherwise `gb_rdata <= 0`. The host sees zero for any miss or write cycle, so an OR-combine upstream is safe.
- **Write counter:** `wr_count` increments by 1 on each cycle where the registered `sub_wstb` is 1. It saturates at 16'hFFFF and does not wrap.
- **Pipelining:** one transaction is accepted per cycle with no stalls. Back-to-back reads, writes and interleavings are all legal.

## Timing

- **Reset:** `gb_rst_n` low clears every output and internal register immediately, asynchronously:
  - `gb_rdata`=0, `sub_addr`=0, `sub_wdata`=0, `sub_wstb`=0, `wr_count`=0.
  - The read shift register is cleared.
  - Deassertion takes effect at the next `gb_clk` edge.
- **Write path latency:** a host write at edge N appears as `sub_wstb`=1 with address and data in the cycle after edge N (1 cycle). `wr_count` updates one cycle later still.
- **Read path latency:**
  - Host read at edge N.
  - `sub_addr` is valid after edge N.
  - `sub_rdata` is sampled at edge N+RD_LAT.
  - `gb_rdata` is valid after edge N+1+RD_LAT.
  - Total host read latency is RD_LAT+2 cycles, constant for every read.
- **Window boundaries:** address `BASE + 2^SUB_AW - 1` hits. `BASE + 2^SUB_AW` and `BASE - 1` miss.
- **Reset mid-read:** all in-flight read returns are discarded. `gb_rdata` stays 0 until a new read completes its full latency after reset release.
- **Write immediately followed by read of the same address:** passes in order. Sub-bus read-after-write semantics are the sub-bus's responsibility.
- **Saturated counter:** `wr_count` at FFFF plus a write stays FFFF. Only reset clears it.

## Test plan

Parameters for all scenarios: BASE=24'h000100, SUB_AW=8, RD_LAT=2, with a sub-bus model that is a 256-word RAM with 2-cycle read.

1. **Reset:** assert `gb_rst_n`=0 mid-clock -> all outputs 0 immediately, before the next edge.
2. **Write hit:** write 24'h000142 with data 32'hDEADBEEF -> next cycle `sub_wstb`=1, `sub_addr`=24'h000042, `sub_wdata`=DEADBEEF. `wr_count`=1 one cycle later.
3. **Miss:**
   - Write 24'h000200 -> `sub_wstb` stays 0, `sub_addr` unchanged, `wr_count` unchanged.
   - Read 24'h0000FF -> `gb_rdata`=0 four cycles later.
4. **Read-back pipeline:** back-to-back reads of 24'h000142 and 24'h0001FF, with RAM holding DEADBEEF at 0x42 and 0x0000A5A5 at 0xFF -> `gb_rdata`=DEADBEEF exactly 4 cycles after the first read, then 0000A5A5 on the following cycle.
5. **Reset mid-read:** issue a read, pulse `gb_rst_n` low after 1 cycle -> `gb_rdata` never shows the RAM value and remains 0.
6. **Saturation:** preload or force `wr_count`=16'hFFFE, then perform 3 window writes -> `wr_count` reads FFFF, FFFF, FFFF.

Source files
------------

// File: rtl/gb_window_bridge_if.sv
// Host-side and sub-bus-side signal bundle for gb_window_bridge.
// The slave modport is the bridge's view. The master modport drives the host and sub-bus inputs.
interface gb_window_bridge_if #(
  parameter int unsigned AW = 24,
  parameter int unsigned DW = 32
);
  logic [AW-1:0] gb_addr;
  logic [DW-1:0] gb_wdata;
  logic          gb_wstb;
  logic [DW-1:0] gb_rdata;
  logic [AW-1:0] sub_addr;
  logic [DW-1:0] sub_wdata;
  logic          sub_wstb;
  logic [DW-1:0] sub_rdata;
  logic [15:0]   wr_count;

  modport slave (
    input  gb_addr, gb_wdata, gb_wstb, sub_rdata,
    output gb_rdata, sub_addr, sub_wdata, sub_wstb, wr_count
  );

  modport master (
    output gb_addr, gb_wdata, gb_wstb, sub_rdata,
    input  gb_rdata, sub_addr, sub_wdata, sub_wstb, wr_count
  );
endinterface

// File: rtl/gb_window_bridge.sv
// Decodes host accesses against a power-of-two window and drives a registered sub-bus.
// Read data returns with a fixed latency of RD_LAT+2 cycles, or zero on a miss or a write.
module gb_window_bridge #(
  parameter int unsigned   AW     = 24,
  parameter int unsigned   DW     = 32,
  parameter int unsigned   SUB_AW = 8,
  parameter logic [AW-1:0] BASE   = 24'h000100,
  parameter int unsigned   RD_LAT = 1
) (
  input  logic gb_clk,
  input  logic gb_rst_n,
  gb_window_bridge_if.slave bus
);

  localparam logic [AW-1:0] BaseLowMask = AW'((64'd1 << SUB_AW) - 64'd1);

  if (SUB_AW < 1 || SUB_AW > AW - 1) begin : g_bad_sub_aw
    $error("gb_window_bridge: SUB_AW out of range 1..AW-1");
  end
  if (RD_LAT < 1 || RD_LAT > 8) begin : g_bad_rd_lat
    $error("gb_window_bridge: RD_LAT out of range 1..8");
  end
  if ((BASE & BaseLowMask) != '0) begin : g_bad_base
    $error("gb_window_bridge: BASE not aligned to window size");
  end

  logic          w_hit;
  logic          w_rd_issue;
  logic [AW-1:0] w_sub_addr_d;

  logic [AW-1:0]   r_sub_addr;
  logic [DW-1:0]   r_sub_wdata;
  logic            r_sub_wstb;
  logic [DW-1:0]   r_gb_rdata;
  logic [15:0]     r_wr_count;
  logic [RD_LAT:0] r_rd_pipe;

  always_comb begin
    w_hit        = (bus.gb_addr[AW-1:SUB_AW] == BASE[AW-1:SUB_AW]);
    w_rd_issue   = w_hit & ~bus.gb_wstb;
    w_sub_addr_d = bus.gb_addr & BaseLowMask;
  end

  // Misses leave the sub-bus address and data frozen so the sub-bus stays quiet.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_sub_addr  <= '0;
      r_sub_wdata <= '0;
      r_sub_wstb  <= 1'b0;
    end else begin
      if (w_hit) begin
        r_sub_addr  <= w_sub_addr_d;
        r_sub_wdata <= bus.gb_wdata;
      end
      r_sub_wstb <= bus.gb_wstb & w_hit;
    end
  end

  // Tap RD_LAT lines up with sub_rdata becoming valid RD_LAT cycles after sub_addr.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_rd_pipe  <= '0;
      r_gb_rdata <= '0;
    end else begin
      r_rd_pipe  <= {r_rd_pipe[RD_LAT-1:0], w_rd_issue};
      r_gb_rdata <= r_rd_pipe[RD_LAT] ? bus.sub_rdata : '0;
    end
  end

  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      r_wr_count <= '0;
    end else if (r_sub_wstb && (r_wr_count != 16'hFFFF)) begin
      r_wr_count <= r_wr_count + 16'd1;
    end
  end

  assign bus.gb_rdata  = r_gb_rdata;
  assign bus.sub_addr  = r_sub_addr;
  assign bus.sub_wdata = r_sub_wdata;
  assign bus.sub_wstb  = r_sub_wstb;
  assign bus.wr_count  = r_wr_count;

endmodule

// File: tb/tb_gb_window_bridge.sv
// Directed bench for gb_window_bridge with a 256-word, 2-cycle-read RAM on the sub-bus.
module tb_gb_window_bridge;

  logic gb_clk;
  logic gb_rst_n;
  int   checks;
  int   passes;

  gb_window_bridge_if #(.AW(24), .DW(32)) bus ();

  gb_window_bridge #(
    .AW    (24),
    .DW    (32),
    .SUB_AW(8),
    .BASE  (24'h000100),
    .RD_LAT(2)
  ) dut (
    .gb_clk  (gb_clk),
    .gb_rst_n(gb_rst_n),
    .bus     (bus)
  );

  initial gb_clk = 1'b0;
  always #5 gb_clk = ~gb_clk;

  // Sub-bus RAM: address registered once inside, data registered once more.
  logic [31:0] ram [256];
  logic [31:0] ram_rd1;
  always @(posedge gb_clk) begin
    if (bus.sub_wstb) ram[bus.sub_addr[7:0]] <= bus.sub_wdata;
    ram_rd1       <= ram[bus.sub_addr[7:0]];
    bus.sub_rdata <= ram_rd1;
  end

  task automatic tick();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic drive(input logic [23:0] a, input logic [31:0] d, input logic w);
    bus.gb_addr  = a;
    bus.gb_wdata = d;
    bus.gb_wstb  = w;
  endtask

  initial begin
    checks   = 0;
    passes   = 0;
    gb_rst_n = 1'b0;
    drive(24'h0, 32'h0, 1'b0);
    #1;
    chk("rst_rdata", bus.gb_rdata, 32'h0);
    chk("rst_sub_addr", 32'(bus.sub_addr), 32'h0);
    chk("rst_sub_wdata", bus.sub_wdata, 32'h0);
    chk("rst_sub_wstb", 32'(bus.sub_wstb), 32'h0);
    chk("rst_wr_count", 32'(bus.wr_count), 32'h0);
    @(negedge gb_clk);
    gb_rst_n = 1'b1;
    tick();

    // Write hit
    drive(24'h000142, 32'hDEADBEEF, 1'b1);
    tick();
    drive(24'h0, 32'h0, 1'b0);
    chk("wr_sub_wstb", 32'(bus.sub_wstb), 32'h1);
    chk("wr_sub_addr", 32'(bus.sub_addr), 32'h42);
    chk("wr_sub_wdata", bus.sub_wdata, 32'hDEADBEEF);
    chk("wr_count_lag", 32'(bus.wr_count), 32'h0);
    tick();
    chk("wr_count_1", 32'(bus.wr_count), 32'h1);
    chk("wr_sub_wstb_off", 32'(bus.sub_wstb), 32'h0);

    // Write miss just past the top of the window
    drive(24'h000200, 32'h12345678, 1'b1);
    tick();
    drive(24'h0, 32'h0, 1'b0);
    chk("miss_wstb", 32'(bus.sub_wstb), 32'h0);
    chk("miss_addr_hold", 32'(bus.sub_addr), 32'h42);
    chk("miss_wdata_hold", bus.sub_wdata, 32'hDEADBEEF);
    tick();
    chk("miss_count", 32'(bus.wr_count), 32'h1);

    // Top word of the window hits
    drive(24'h0001FF, 32'h0000A5A5, 1'b1);
    tick();
    drive(24'h0, 32'h0, 1'b0);
    chk("top_wstb", 32'(bus.sub_wstb), 32'h1);
    chk("top_addr", 32'(bus.sub_addr), 32'hFF);
    tick();
    chk("top_count", 32'(bus.wr_count), 32'h2);

    // Read miss just below the window; RAM[0xFF] holds A5A5 but must not leak
    drive(24'h0000FF, 32'h0, 1'b0);
    tick();
    drive(24'h0, 32'h0, 1'b0);
    chk("rmiss_addr_hold", 32'(bus.sub_addr), 32'hFF);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rmiss_rdata", bus.gb_rdata, 32'h0);
    end

    // Back-to-back reads
    drive(24'h000142, 32'h0, 1'b0);
    tick();
    drive(24'h0001FF, 32'h0, 1'b0);
    tick();
    drive(24'h0, 32'h0, 1'b0);
    tick();
    chk("pipe_early", bus.gb_rdata, 32'h0);
    tick();
    chk("pipe_rd0", bus.gb_rdata, 32'hDEADBEEF);
    tick();
    chk("pipe_rd1", bus.gb_rdata, 32'h0000A5A5);
    tick();
    chk("pipe_idle", bus.gb_rdata, 32'h0);

    // Reset mid-read
    drive(24'h000142, 32'h0, 1'b0);
    tick();
    drive(24'h0, 32'h0, 1'b0);
    tick();
    gb_rst_n = 1'b0;
    #1;
    chk("mid_rst_addr", 32'(bus.sub_addr), 32'h0);
    chk("mid_rst_count", 32'(bus.wr_count), 32'h0);
    chk("mid_rst_rdata", bus.gb_rdata, 32'h0);
    @(negedge gb_clk);
    gb_rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("mid_rst_quiet", bus.gb_rdata, 32'h0);
    end

    // Saturation: 65534 writes reach FFFE, then three more stay at FFFF
    drive(24'h000142, 32'h0BADF00D, 1'b1);
    repeat (65534) tick();
    drive(24'h0, 32'h0, 1'b0);
    tick();
    tick();
    chk("sat_fffe", 32'(bus.wr_count), 32'hFFFE);
    for (int i = 0; i < 3; i++) begin
      drive(24'h000100, 32'h0, 1'b1);
      tick();
      drive(24'h0, 32'h0, 1'b0);
      tick();
      chk("sat_ffff", 32'(bus.wr_count), 32'hFFFF);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
